// File: rtl/trig_pkg.sv
// Shared definitions for the LV1b trigger issuer.
//   N_TYPE_DEF / HOLD_W_DEF / CNT_W_DEF : default widths used by the issuer
//   state_t                             : issuer FSM states
//   SAT_MAX                             : saturation ceiling of a default-width counter
package trig_pkg;

  localparam int N_TYPE_DEF = 8;
  localparam int HOLD_W_DEF = 16;
  localparam int CNT_W_DEF  = 32;

  localparam logic [CNT_W_DEF-1:0] SAT_MAX = {CNT_W_DEF{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

endpackage

// File: rtl/trig_sat_cnt.sv
// Saturating up-counter with synchronous clear and increment.
// A clear and an increment in the same cycle load 0 + inc, so an event that
// coincides with the start of a run is still counted.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear
//   inc      : count one
//   q        : count value, sticks at all-ones
module trig_sat_cnt
  import trig_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    if (en && (v != MAX)) return v + CNT_W'(1);
    return v;
  endfunction

  logic [CNT_W-1:0] base;

  assign base = clr ? '0 : q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= sat_inc(base, inc);
  end

endmodule

// File: rtl/trig_lv1b_issuer.sv
// Merges per-type LV1b bits into one accepted LV1b pulse with a latched
// trigger-type word, a busy veto and a programmable holdoff; keeps per-run
// raw/accepted/vetoed counters and an event number.
//   clk, rst        : clock, asynchronous active-high reset
//   in_live         : run live, rising edge starts a new run
//   in_ena          : global trigger enable
//   in_busy         : downstream busy, vetoes acceptance while idle
//   in_type_raw     : per-type raw LV1b pulses
//   in_type_scaled  : per-type prescaled LV1b pulses
//   user_type_mask  : 1 = type participates
//   user_holdoff    : dead-time cycles after each issued trigger
//   out_lv1b        : accepted LV1b, one-cycle pulse
//   out_trig_word   : masked scaled bits of the last accepted trigger
//   out_event_num   : event number of last accepted trigger
//   raw_cnt, acc_cnt, veto_cnt : per-run counters
module trig_lv1b_issuer
  import trig_pkg::*;
#(
  parameter int N_TYPE = N_TYPE_DEF,
  parameter int HOLD_W = HOLD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_live,
  input  logic              in_ena,
  input  logic              in_busy,
  input  logic [N_TYPE-1:0] in_type_raw,
  input  logic [N_TYPE-1:0] in_type_scaled,
  input  logic [N_TYPE-1:0] user_type_mask,
  input  logic [HOLD_W-1:0] user_holdoff,
  output logic              out_lv1b,
  output logic [N_TYPE-1:0] out_trig_word,
  output logic [CNT_W-1:0]  out_event_num,
  output logic [CNT_W-1:0]  raw_cnt,
  output logic [CNT_W-1:0]  acc_cnt,
  output logic [CNT_W-1:0]  veto_cnt
);

  state_t            state, state_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic              pre_live;
  logic              gate, cand, rawhit, run_clr;
  logic              accept, veto_inc;
  logic [N_TYPE-1:0] cand_word;

  assign gate      = in_live & in_ena;
  assign cand_word = in_type_scaled & user_type_mask;
  assign cand      = gate & (|cand_word);
  assign rawhit    = gate & (|(in_type_raw & user_type_mask));
  assign run_clr   = ~pre_live & in_live;

  // Candidates are dropped (not queued) whenever the issuer cannot take them.
  assign veto_inc  = cand & ((state != IDLE) | in_busy);

  // The pulse is a straight decode of the registered state.
  assign out_lv1b  = (state == ISSUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      pre_live <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      pre_live <= in_live;
    end
  end

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (cand && !in_busy) begin
          state_n = ISSUE;
          accept  = 1'b1;
        end
      end
      ISSUE: begin
        // Holdoff is loaded only here, so mid-holdoff changes wait for the next trigger.
        if (user_holdoff != '0) begin
          state_n = HOLDOFF;
          hold_n  = user_holdoff;
        end else begin
          state_n = IDLE;
        end
      end
      HOLDOFF: begin
        if (hold_cnt == HOLD_W'(1)) begin
          state_n = IDLE;
          hold_n  = '0;
        end else begin
          hold_n  = hold_cnt - HOLD_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        hold_n  = '0;
      end
    endcase
  end

  // A new accept in the run-start cycle takes precedence over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          out_trig_word <= '0;
    else if (accept)  out_trig_word <= cand_word;
    else if (run_clr) out_trig_word <= '0;
  end

  trig_sat_cnt #(.CNT_W(CNT_W)) u_raw (
    .clk(clk), .rst(rst), .clr(run_clr), .inc(rawhit),   .q(raw_cnt)
  );

  trig_sat_cnt #(.CNT_W(CNT_W)) u_acc (
    .clk(clk), .rst(rst), .clr(run_clr), .inc(out_lv1b), .q(acc_cnt)
  );

  trig_sat_cnt #(.CNT_W(CNT_W)) u_veto (
    .clk(clk), .rst(rst), .clr(run_clr), .inc(veto_inc), .q(veto_cnt)
  );

  trig_sat_cnt #(.CNT_W(CNT_W)) u_evt (
    .clk(clk), .rst(rst), .clr(run_clr), .inc(out_lv1b), .q(out_event_num)
  );

endmodule
